// File: rtl/bram_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_capture_ctrl
// Description : Trigger-driven capture sequencer for a BRAM sample store.
//               Arm latches the delay / length configuration, a rising edge
//               of trigger starts the delay phase, then write_enable is held
//               high for exactly num_samples consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_capture_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm_i,
  input  logic             trigger_i,
  input  logic             abort_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] delay_cycles_i,
  input  logic [CNT_W-1:0] num_samples_i,
  output logic             write_enable_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [CNT_W-1:0] sample_count_o,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e           state_q;
  logic             trig_q;
  logic [CNT_W-1:0] delay_lat_q;
  logic [CNT_W-1:0] nsamp_lat_q;
  logic [CNT_W-1:0] dly_cnt_q;
  logic [CNT_W-1:0] sample_count_q;
  logic             we_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;

  logic             trig_rise;
  logic             last_write;
  logic             delay_done;

  // Rising edge of the trigger level relative to the previous cycle.
  assign trig_rise  = trigger_i & ~trig_q;
  // The current write is the final one of the burst (only meaningful with
  // a non-zero latched length, which CAPTURE guarantees).
  assign last_write = (sample_count_q == (nsamp_lat_q - CNT_ONE));
  // The delay counter starts at 1 on DELAY entry, so equality marks the
  // last DELAY cycle.
  assign delay_done = (dly_cnt_q == delay_lat_q);

  // Trigger history register, updated every cycle regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trigger_i;
    end
  end

  // Capture sequencer with all status outputs registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      delay_lat_q    <= CNT_ZERO;
      nsamp_lat_q    <= CNT_ZERO;
      dly_cnt_q      <= CNT_ZERO;
      sample_count_q <= CNT_ZERO;
      we_q           <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // Arm beats clear when both arrive together in DONE.
          if (arm_i) begin
            delay_lat_q    <= delay_cycles_i;
            nsamp_lat_q    <= num_samples_i;
            sample_count_q <= CNT_ZERO;
            aborted_q      <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= ST_ARMED;
          end else if (clear_i && (state_q == ST_DONE)) begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end

        ST_ARMED: begin
          if (abort_i) begin
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (trig_rise) begin
            if (nsamp_lat_q == CNT_ZERO) begin
              // Zero-length capture completes without any write cycle.
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else if (delay_lat_q == CNT_ZERO) begin
              we_q    <= 1'b1;
              state_q <= ST_CAPTURE;
            end else begin
              dly_cnt_q <= CNT_ONE;
              state_q   <= ST_DELAY;
            end
          end
        end

        ST_DELAY: begin
          if (abort_i) begin
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (delay_done) begin
            we_q    <= 1'b1;
            state_q <= ST_CAPTURE;
          end else begin
            dly_cnt_q <= dly_cnt_q + CNT_ONE;
          end
        end

        ST_CAPTURE: begin
          // The write in this cycle has happened even if abort is raised,
          // so it is always counted.
          sample_count_q <= sample_count_q + CNT_ONE;
          if (abort_i) begin
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (last_write) begin
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        default: begin
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign write_enable_o = we_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign aborted_o      = aborted_q;
  assign sample_count_o = sample_count_q;
  assign state_o        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_capture_ctrl
// Description : Scoreboard bench for bram_capture_ctrl. Stimulus pushes the
//               expected write burst; a monitor measures each burst on the
//               falling clock edge and pops/compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_capture_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             arm_i;
  logic             trigger_i;
  logic             abort_i;
  logic             clear_i;
  logic [CNT_W-1:0] delay_cycles_i;
  logic [CNT_W-1:0] num_samples_i;
  logic             write_enable_o;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  logic [CNT_W-1:0] sample_count_o;
  logic [2:0]       state_o;

  bram_capture_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arm_i          (arm_i),
    .trigger_i      (trigger_i),
    .abort_i        (abort_i),
    .clear_i        (clear_i),
    .delay_cycles_i (delay_cycles_i),
    .num_samples_i  (num_samples_i),
    .write_enable_o (write_enable_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .aborted_o      (aborted_o),
    .sample_count_o (sample_count_o),
    .state_o        (state_o)
  );

  typedef struct {
    int start;
    int len;
    int st;
    int cnt;
    int ab;
  } burst_t;

  burst_t sb[$];
  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  int     bstart = 0;
  int     blen   = 0;
  logic   prev_we = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: measure each write_enable burst and compare against the queue.
  always @(negedge clk) begin
    if (write_enable_o) begin
      if (!prev_we) begin
        bstart = cyc;
        blen   = 0;
      end
      blen++;
    end else if (prev_we) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_burst: got start=%0d len=%0d expected no burst", bstart, blen);
      end else begin
        burst_t e;
        e = sb.pop_front();
        chk("burst_start", bstart, e.start);
        chk("burst_len", blen, e.len);
        chk("burst_end_state", int'(state_o), e.st);
        chk("burst_end_count", int'(sample_count_o), e.cnt);
        chk("burst_end_aborted", int'(aborted_o), e.ab);
      end
    end
    prev_we = write_enable_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_arm(input int d, input int n);
    delay_cycles_i = CNT_W'(d);
    num_samples_i  = CNT_W'(n);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic trig_pulse();
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
  endtask

  task automatic expect_burst(input int start, input int len, input int st,
                              input int cnt, input int ab);
    burst_t e;
    e.start = start;
    e.len   = len;
    e.st    = st;
    e.cnt   = cnt;
    e.ab    = ab;
    sb.push_back(e);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    arm_i = 1'b0;
    trigger_i = 1'b0;
    abort_i = 1'b0;
    clear_i = 1'b0;
    delay_cycles_i = '0;
    num_samples_i  = '0;
    tick();
    tick();
    // Reset values
    chk("rst_state", int'(state_o), 0);
    chk("rst_we", int'(write_enable_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_aborted", int'(aborted_o), 0);
    chk("rst_count", int'(sample_count_o), 0);
    rst_n = 1'b1;
    tick();

    // Basic capture: delay 0, 4 samples
    do_arm(0, 4);
    chk("armed_state", int'(state_o), 1);
    chk("armed_busy", int'(busy_o), 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear_ignored_armed", int'(state_o), 1);
    tick();
    k = cyc;
    expect_burst(k + 1, 4, 4, 4, 0);
    trig_pulse();
    wait_cyc(k + 8);
    chk("basic_done", int'(done_o), 1);
    chk("basic_busy", int'(busy_o), 0);
    chk("basic_count", int'(sample_count_o), 4);

    // Delayed capture with trigger held high
    do_arm(5, 2);
    k = cyc;
    expect_burst(k + 6, 2, 4, 2, 0);
    trigger_i = 1'b1;
    wait_cyc(k + 16);
    chk("delay_no_retrig_state", int'(state_o), 4);
    chk("delay_done", int'(done_o), 1);
    trigger_i = 1'b0;
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear_to_idle", int'(state_o), 0);
    chk("clear_done_low", int'(done_o), 0);

    // Abort during the 4th write of a 10-word capture
    do_arm(0, 10);
    k = cyc;
    expect_burst(k + 1, 4, 0, 4, 1);
    trig_pulse();
    wait_cyc(k + 4);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_state", int'(state_o), 0);
    chk("abort_we", int'(write_enable_o), 0);
    chk("abort_flag", int'(aborted_o), 1);
    chk("abort_count", int'(sample_count_o), 4);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_idle_ignored", int'(state_o), 0);
    chk("aborted_sticky", int'(aborted_o), 1);

    // Zero-length capture
    do_arm(3, 0);
    chk("arm_clears_aborted", int'(aborted_o), 0);
    trig_pulse();
    tick();
    chk("zero_state", int'(state_o), 4);
    chk("zero_count", int'(sample_count_o), 0);
    chk("zero_done", int'(done_o), 1);

    // Arm and clear together in DONE: arm wins, then 3 writes
    delay_cycles_i = '0;
    num_samples_i  = CNT_W'(3);
    arm_i   = 1'b1;
    clear_i = 1'b1;
    tick();
    arm_i   = 1'b0;
    clear_i = 1'b0;
    chk("arm_beats_clear", int'(state_o), 1);
    k = cyc;
    expect_burst(k + 1, 3, 4, 3, 0);
    trig_pulse();
    wait_cyc(k + 7);
    chk("rearm_done", int'(done_o), 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;

    // Trigger while IDLE is ignored; count keeps the last capture
    trig_pulse();
    repeat (6) tick();
    chk("idle_trig_state", int'(state_o), 0);
    chk("idle_count_held", int'(sample_count_o), 3);

    // Maximum length: no wrap
    do_arm(0, 255);
    k = cyc;
    expect_burst(k + 1, 255, 4, 255, 0);
    trig_pulse();
    wait_cyc(k + 260);
    chk("max_done", int'(done_o), 1);
    chk("max_count", int'(sample_count_o), 255);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;

    // Reset mid-capture
    do_arm(0, 20);
    k = cyc;
    expect_burst(k + 1, 4, 0, 0, 0);
    trig_pulse();
    wait_cyc(k + 5);
    rst_n = 1'b0;
    #1;
    chk("rstmid_we_async", int'(write_enable_o), 0);
    chk("rstmid_state", int'(state_o), 0);
    chk("rstmid_busy", int'(busy_o), 0);
    chk("rstmid_count", int'(sample_count_o), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    trig_pulse();
    repeat (8) tick();
    chk("post_rst_no_capture", int'(state_o), 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_capture_ctrl.md
BRAM_CAPTURE_CTRL -- requirements
Module: bram_capture_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the sample-count and delay-count fields.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 arm  input  1  single-cycle pulse; latches the configuration and arms the capture.
REQ-005 trigger  input  1  level input; a capture starts on its rising edge.
REQ-006 abort  input  1  level input; terminates any capture in progress.
REQ-007 clear  input  1  single-cycle pulse; acknowledges done and returns the block to IDLE.
REQ-008 delay_cycles  input  CNT_W  number of cycles from trigger edge to first write.
REQ-009 num_samples  input  CNT_W  number of words to write.
REQ-010 write_enable  output  1  registered; drives the write-enable input of the BRAM store.
REQ-011 busy  output  1  high in ARMED, DELAY and CAPTURE.
REQ-012 done  output  1  high in DONE only.
REQ-013 aborted  output  1  sticky flag, set by abort; cleared by arm or clear.
REQ-014 sample_count  output  CNT_W  number of words written in the current or last capture.
REQ-015 state  output  3  encoding IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4.

Function
REQ-016 The block SHALL implement the FSM IDLE -> ARMED -> DELAY -> CAPTURE -> DONE -> IDLE.
REQ-017 arm in IDLE or DONE SHALL:
- latch delay_cycles and num_samples into internal registers;
- clear sample_count and aborted;
- go to ARMED.
REQ-018 arm in ARMED, DELAY or CAPTURE SHALL be ignored.
REQ-019 trigger SHALL be registered once; edge = trigger & ~trigger_q, and trigger_q SHALL be updated every cycle in every state.
REQ-020 A trigger edge SHALL be acted on only in ARMED; trigger levels and edges in all other states SHALL be ignored.
REQ-021 On an edge in ARMED:
- latched num_samples == 0 -> DONE;
- else latched delay == 0 -> CAPTURE;
- else -> DELAY.
REQ-022 DELAY SHALL last exactly the latched delay in cycles, then go to CAPTURE.
REQ-023 Trigger-edge cycle to first write_enable cycle SHALL be 1 + delay cycles.
REQ-024 write_enable SHALL be high for exactly num_samples consecutive cycles, equivalent to (state == CAPTURE).
REQ-025 sample_count SHALL increment on each write_enable cycle; no other write gaps are allowed.
REQ-026 The cycle after the last write SHALL enter DONE with write_enable low and sample_count == num_samples.
REQ-027 In DONE, done SHALL stay high until clear (-> IDLE) or arm (-> ARMED).
REQ-028 clear outside DONE SHALL be ignored.
REQ-029 abort in ARMED, DELAY or CAPTURE SHALL, on the next edge:
- go to IDLE;
- drop write_enable;
- set aborted;
- hold sample_count at the number of words already written.
REQ-030 abort has priority over trigger, arm and count completion in the same cycle.
REQ-031 abort in IDLE or DONE SHALL be ignored.
REQ-032 Counters SHALL NOT wrap: num_samples = 2^CNT_W-1 SHALL produce exactly that many writes.
REQ-033 Every write_enable deassertion SHALL last at least one cycle, so that the downstream address counter rewinds to word 0 before the next capture.
REQ-034 Simultaneous arm and clear in DONE: arm SHALL win.

Reset
REQ-035 rst_n low SHALL immediately force:
- state = IDLE, write_enable = 0, busy = 0, done = 0, aborted = 0;
- sample_count = 0, trigger_q = 0, latched configuration = 0.
REQ-036 Reset asserted mid-capture SHALL drop write_enable asynchronously, without waiting for a clock edge.
REQ-037 After rst_n is released, the block SHALL require a new arm before it responds to trigger.

Verification
REQ-038 Basic capture:
- arm with delay = 0, num_samples = 4; trigger rises 3 cycles later;
- write_enable high for 4 cycles starting the cycle after the edge;
- then done = 1, sample_count = 4.
REQ-039 Delayed capture:
- delay = 5, num_samples = 2;
- first write exactly 6 cycles after the edge;
- trigger held high throughout causes no re-trigger.
REQ-040 Abort:
- num_samples = 10; abort asserted during the 4th write cycle;
- write_enable low on the next edge, state = IDLE, aborted = 1, sample_count = 4.
REQ-041 Zero length:
- num_samples = 0 followed by a trigger edge;
- ARMED -> DONE with no write_enable cycle and sample_count = 0.
REQ-042 Re-arm and ignored inputs:
- arm in DONE with num_samples = 3 -> a second trigger yields 3 writes;
- a trigger edge while IDLE produces no writes.
REQ-043 Reset mid-capture:
- rst_n pulsed low during CAPTURE;
- write_enable low within the same cycle, all outputs at reset values;
- a subsequent trigger with no arm produces no writes.
